// File: rtl/bus_xfer_sequencer_pkg.sv
// rtl/bus_xfer_sequencer_pkg.sv - shared states, defaults and request field layout for the transfer sequencer
package bus_xfer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SW   = 2'd1,
    ST_ADP  = 2'd2,
    ST_BUSY = 2'd3
  } xfer_state_t;

  localparam int N_DEFAULT          = 4;
  localparam int OUTER_PORT_DEFAULT = 0;
  localparam int MAXLEN_DEFAULT     = 15;

  // Request word layout, LSB first: srcMask, dstMask, size, conv
  function automatic int req_dst_lsb(input int n);
    return n;
  endfunction

  function automatic int req_size_lsb(input int n);
    return 2 * n;
  endfunction

  function automatic int req_conv_bit(input int n, input int maxlen);
    return 2 * n + maxlen;
  endfunction

  // Outer adapter command word is {conv, size} on both the in and out side
  function automatic int outer_cmd_width(input int maxlen);
    return 1 + maxlen;
  endfunction

endpackage

// File: rtl/bus_xfer_sequencer_req_check.sv
// rtl/bus_xfer_sequencer_req_check.sv - combinational validation of an incoming transfer request
module xfer_req_check #(
  parameter int N          = 4,
  parameter int OUTER_PORT = 0,
  parameter int MAXLEN     = 15
) (
  input  logic [N-1:0]      src_mask,
  input  logic [N-1:0]      dst_mask,
  input  logic [MAXLEN-1:0] size,
  output logic              req_ok
);

  localparam logic [N-1:0] ONE = N'(1);

  logic src_one_hot;
  logic dst_nonzero;
  logic outer_zero_size;

  always_comb begin
    src_one_hot     = (src_mask != '0) && ((src_mask & (src_mask - ONE)) == '0);
    dst_nonzero     = (dst_mask != '0);
    // The outer adapters need a word count; the internal ports run on isLast alone
    outer_zero_size = (size == '0) && (src_mask[OUTER_PORT] || dst_mask[OUTER_PORT]);
    req_ok          = src_one_hot && dst_nonzero && !outer_zero_size;
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// rtl/bus_xfer_sequencer.sv - issues switch route and outer adapter commands for one transfer, reports done
module bus_xfer_sequencer
  import bus_xfer_sequencer_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int OUTER_PORT = OUTER_PORT_DEFAULT,
  parameter int MAXLEN     = MAXLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*N+MAXLEN:0]   req,
  input  logic                  req_isReady,
  output logic                  req_canReceive,
  output logic [2*N-1:0]        sw_cmd,
  output logic                  sw_cmd_isReady,
  input  logic                  sw_cmd_canReceive,
  output logic [MAXLEN:0]       oin_cmd,
  output logic                  oin_cmd_isReady,
  input  logic                  oin_cmd_canReceive,
  output logic [MAXLEN:0]       oout_cmd,
  output logic                  oout_cmd_isReady,
  input  logic                  oout_cmd_canReceive,
  input  logic [N-1:0]          src_isLast,
  output logic                  done,
  output logic                  err
);

  localparam int DST_LSB  = req_dst_lsb(N);
  localparam int SIZE_LSB = req_size_lsb(N);
  localparam int CONV_BIT = req_conv_bit(N, MAXLEN);
  localparam int CMD_W    = outer_cmd_width(MAXLEN);

  xfer_state_t       state_q, state_d;
  logic [N-1:0]      src_q, src_d;
  logic [N-1:0]      dst_q, dst_d;
  logic [MAXLEN-1:0] size_q, size_d;
  logic              conv_q, conv_d;
  logic              sw_vld_q, sw_vld_d;
  logic              oin_pend_q, oin_pend_d;
  logic              oout_pend_q, oout_pend_d;
  logic              last_seen_q, last_seen_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [N-1:0]      req_src;
  logic [N-1:0]      req_dst;
  logic [MAXLEN-1:0] req_size;
  logic              req_conv;
  logic              req_ok;
  logic              src_hit;
  logic              need_oin;
  logic              need_oout;

  assign req_src  = req[N-1:0];
  assign req_dst  = req[DST_LSB +: N];
  assign req_size = req[SIZE_LSB +: MAXLEN];
  assign req_conv = req[CONV_BIT];

  xfer_req_check #(
    .N          (N),
    .OUTER_PORT (OUTER_PORT),
    .MAXLEN     (MAXLEN)
  ) u_req_check (
    .src_mask (req_src),
    .dst_mask (req_dst),
    .size     (req_size),
    .req_ok   (req_ok)
  );

  assign src_hit   = |(src_isLast & src_q);
  assign need_oin  = src_q[OUTER_PORT];
  assign need_oout = dst_q[OUTER_PORT];

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    size_d      = size_q;
    conv_d      = conv_q;
    sw_vld_d    = sw_vld_q;
    oin_pend_d  = oin_pend_q;
    oout_pend_d = oout_pend_q;
    last_seen_d = last_seen_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_isReady) begin
          if (req_ok) begin
            src_d       = req_src;
            dst_d       = req_dst;
            size_d      = req_size;
            conv_d      = req_conv;
            last_seen_d = 1'b0;
            sw_vld_d    = 1'b1;
            state_d     = ST_SW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SW: begin
        last_seen_d = last_seen_q | src_hit;
        if (sw_cmd_canReceive) begin
          sw_vld_d    = 1'b0;
          oin_pend_d  = need_oin;
          oout_pend_d = need_oout;
          state_d     = (need_oin || need_oout) ? ST_ADP : ST_BUSY;
        end
      end
      ST_ADP: begin
        // Short transfers can finish on the source side before the adapters take their commands
        last_seen_d = last_seen_q | src_hit;
        if (oin_pend_q && oin_cmd_canReceive) begin
          oin_pend_d = 1'b0;
        end
        if (oout_pend_q && oout_cmd_canReceive) begin
          oout_pend_d = 1'b0;
        end
        if (!oin_pend_d && !oout_pend_d) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_seen_q || src_hit) begin
          done_d      = 1'b1;
          last_seen_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      size_q      <= '0;
      conv_q      <= 1'b0;
      sw_vld_q    <= 1'b0;
      oin_pend_q  <= 1'b0;
      oout_pend_q <= 1'b0;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      size_q      <= size_d;
      conv_q      <= conv_d;
      sw_vld_q    <= sw_vld_d;
      oin_pend_q  <= oin_pend_d;
      oout_pend_q <= oout_pend_d;
      last_seen_q <= last_seen_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_canReceive   = (state_q == ST_IDLE);
  assign sw_cmd           = {dst_q, src_q};
  assign sw_cmd_isReady   = sw_vld_q;
  assign oin_cmd          = CMD_W'({conv_q, size_q});
  assign oin_cmd_isReady  = oin_pend_q;
  assign oout_cmd         = CMD_W'({conv_q, size_q});
  assign oout_cmd_isReady = oout_pend_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb/tb_bus_xfer_sequencer.sv - directed self-checking bench for bus_xfer_sequencer
module tb_bus_xfer_sequencer;

  localparam int N      = 4;
  localparam int MAXLEN = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic [2*N+MAXLEN:0] req;
  logic                req_isReady;
  logic                req_canReceive;
  logic [2*N-1:0]      sw_cmd;
  logic                sw_cmd_isReady;
  logic                sw_cmd_canReceive;
  logic [MAXLEN:0]     oin_cmd;
  logic                oin_cmd_isReady;
  logic                oin_cmd_canReceive;
  logic [MAXLEN:0]     oout_cmd;
  logic                oout_cmd_isReady;
  logic                oout_cmd_canReceive;
  logic [N-1:0]        src_isLast;
  logic                done;
  logic                err;

  int checks = 0;
  int errors = 0;

  bus_xfer_sequencer #(.N(N), .OUTER_PORT(0), .MAXLEN(MAXLEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .req_isReady         (req_isReady),
    .req_canReceive      (req_canReceive),
    .sw_cmd              (sw_cmd),
    .sw_cmd_isReady      (sw_cmd_isReady),
    .sw_cmd_canReceive   (sw_cmd_canReceive),
    .oin_cmd             (oin_cmd),
    .oin_cmd_isReady     (oin_cmd_isReady),
    .oin_cmd_canReceive  (oin_cmd_canReceive),
    .oout_cmd            (oout_cmd),
    .oout_cmd_isReady    (oout_cmd_isReady),
    .oout_cmd_canReceive (oout_cmd_canReceive),
    .src_isLast          (src_isLast),
    .done                (done),
    .err                 (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*N+MAXLEN:0] mk_req(input logic conv, input logic [MAXLEN-1:0] size,
                                                 input logic [N-1:0] dst, input logic [N-1:0] src);
    return {conv, size, dst, src};
  endfunction

  task automatic idle_outputs(input string tag);
    chk({tag, "_canrx"}, 32'(req_canReceive), 32'h1);
    chk({tag, "_swrdy"}, 32'(sw_cmd_isReady), 32'h0);
    chk({tag, "_oinrdy"}, 32'(oin_cmd_isReady), 32'h0);
    chk({tag, "_ooutrdy"}, 32'(oout_cmd_isReady), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_isReady = 1'b0;
    sw_cmd_canReceive = 1'b1;
    oin_cmd_canReceive = 1'b1;
    oout_cmd_canReceive = 1'b1;
    src_isLast = '0;
    tick();
    tick();

    // reset state
    idle_outputs("rst");
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_swcmd", 32'(sw_cmd), 32'h0);
    chk("rst_oincmd", 32'(oin_cmd), 32'h0);
    chk("rst_ooutcmd", 32'(oout_cmd), 32'h0);
    rst = 1'b0;
    tick();

    // 1: internal ports only, no adapter commands
    req = mk_req(1'b0, 15'd5, 4'b0100, 4'b0010);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    chk("t1_swrdy", 32'(sw_cmd_isReady), 32'h1);
    chk("t1_swcmd", 32'(sw_cmd), 32'h42);
    chk("t1_canrx", 32'(req_canReceive), 32'h0);
    tick();
    chk("t1_swrdy_drop", 32'(sw_cmd_isReady), 32'h0);
    chk("t1_oinrdy", 32'(oin_cmd_isReady), 32'h0);
    chk("t1_ooutrdy", 32'(oout_cmd_isReady), 32'h0);
    // a bad request while busy must be ignored
    req = mk_req(1'b0, 15'd1, 4'b0001, 4'b0011);
    req_isReady = 1'b1;
    tick();
    chk("t1_busy_noerr", 32'(err), 32'h0);
    chk("t1_busy_swcmd", 32'(sw_cmd), 32'h42);
    req_isReady = 1'b0;
    src_isLast = 4'b0001;
    tick();
    chk("t1_unsel_last", 32'(done), 32'h0);
    src_isLast = 4'b0010;
    tick();
    src_isLast = 4'b0000;
    chk("t1_done", 32'(done), 32'h1);
    tick();
    idle_outputs("t1_end");

    // 2: outer source, conv forwarded to oin only
    req = mk_req(1'b1, 15'd7, 4'b1000, 4'b0001);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    chk("t2_swcmd", 32'(sw_cmd), 32'h81);
    tick();
    chk("t2_oinrdy", 32'(oin_cmd_isReady), 32'h1);
    chk("t2_oincmd", 32'(oin_cmd), 32'h8007);
    chk("t2_ooutrdy", 32'(oout_cmd_isReady), 32'h0);
    tick();
    chk("t2_oinrdy_drop", 32'(oin_cmd_isReady), 32'h0);
    chk("t2_nodone", 32'(done), 32'h0);
    src_isLast = 4'b0001;
    tick();
    src_isLast = 4'b0000;
    chk("t2_done", 32'(done), 32'h1);
    tick();

    // 3: loopback through outer, oin stalled for 3 cycles
    oin_cmd_canReceive = 1'b0;
    req = mk_req(1'b0, 15'd3, 4'b0001, 4'b0001);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    tick();
    chk("t3_oinrdy", 32'(oin_cmd_isReady), 32'h1);
    chk("t3_ooutrdy", 32'(oout_cmd_isReady), 32'h1);
    chk("t3_ooutcmd", 32'(oout_cmd), 32'h0003);
    tick();
    chk("t3_oout_acc", 32'(oout_cmd_isReady), 32'h0);
    chk("t3_oin_held", 32'(oin_cmd_isReady), 32'h1);
    chk("t3_oincmd_stable", 32'(oin_cmd), 32'h0003);
    tick();
    tick();
    chk("t3_oin_held3", 32'(oin_cmd_isReady), 32'h1);
    oin_cmd_canReceive = 1'b1;
    tick();
    chk("t3_oin_acc", 32'(oin_cmd_isReady), 32'h0);
    src_isLast = 4'b0001;
    tick();
    src_isLast = 4'b0000;
    chk("t3_done", 32'(done), 32'h1);
    tick();

    // 4: rejected requests
    req = mk_req(1'b0, 15'd2, 4'b0100, 4'b0011);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    chk("t4_err_src", 32'(err), 32'h1);
    chk("t4_canrx", 32'(req_canReceive), 32'h1);
    chk("t4_swrdy", 32'(sw_cmd_isReady), 32'h0);
    tick();
    chk("t4_err_pulse", 32'(err), 32'h0);
    req = mk_req(1'b0, 15'd2, 4'b0000, 4'b0010);
    req_isReady = 1'b1;
    tick();
    chk("t4_err_dst0", 32'(err), 32'h1);
    req = mk_req(1'b0, 15'd0, 4'b0010, 4'b0001);
    tick();
    req_isReady = 1'b0;
    chk("t4_err_size0", 32'(err), 32'h1);
    chk("t4_swrdy2", 32'(sw_cmd_isReady), 32'h0);
    tick();

    // size 0 between internal ports is legal; isLast already present gives minimum latency
    src_isLast = 4'b0010;
    req = mk_req(1'b0, 15'd0, 4'b0100, 4'b0010);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    chk("lat_noerr", 32'(err), 32'h0);
    chk("lat_swrdy", 32'(sw_cmd_isReady), 32'h1);
    tick();
    chk("lat_nodone", 32'(done), 32'h0);
    tick();
    src_isLast = 4'b0000;
    chk("lat_done", 32'(done), 32'h1);
    tick();

    // 5: isLast pulse during ADP is remembered
    oin_cmd_canReceive = 1'b0;
    req = mk_req(1'b0, 15'd1, 4'b0010, 4'b0001);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    tick();
    src_isLast = 4'b0001;
    tick();
    src_isLast = 4'b0000;
    oin_cmd_canReceive = 1'b1;
    tick();
    chk("t5_enter_busy", 32'(done), 32'h0);
    chk("t5_oin_acc", 32'(oin_cmd_isReady), 32'h0);
    tick();
    chk("t5_done", 32'(done), 32'h1);
    tick();
    chk("t5_done_once", 32'(done), 32'h0);

    // 6: reset in BUSY aborts without done
    req = mk_req(1'b0, 15'd4, 4'b1000, 4'b0100);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    tick();
    rst = 1'b1;
    src_isLast = 4'b0100;
    tick();
    rst = 1'b0;
    src_isLast = 4'b0000;
    idle_outputs("t6_abort");
    chk("t6_swcmd_clr", 32'(sw_cmd), 32'h0);
    tick();
    chk("t6_nodone", 32'(done), 32'h0);
    req = mk_req(1'b0, 15'd2, 4'b0001, 4'b0010);
    req_isReady = 1'b1;
    tick();
    req_isReady = 1'b0;
    chk("t6_swcmd", 32'(sw_cmd), 32'h12);
    tick();
    chk("t6_ooutrdy", 32'(oout_cmd_isReady), 32'h1);
    chk("t6_ooutcmd", 32'(oout_cmd), 32'h0002);
    chk("t6_oinrdy", 32'(oin_cmd_isReady), 32'h0);
    tick();
    src_isLast = 4'b0010;
    tick();
    src_isLast = 4'b0000;
    chk("t6_done", 32'(done), 32'h1);
    tick();
    idle_outputs("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
